// File: rtl/fwd_pkg.sv
// Shared constants and shadow-slot type for the decode-stage forwarding/hazard controller.
// Select codes are the ones decoded by the 32-bit 4:1 operand muxes in EX.
package fwd_pkg;

  localparam int REG_W = 5;
  localparam int CNT_W = 16;
  localparam int SEL_W = 3;

  localparam logic [SEL_W-1:0] FWD_RF  = 3'd0;
  localparam logic [SEL_W-1:0] FWD_EX  = 3'd1;
  localparam logic [SEL_W-1:0] FWD_MEM = 3'd2;
  localparam logic [SEL_W-1:0] FWD_WB  = 3'd3;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             regwrite;
    logic             load;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A slot produces a value for src only if it really writes that register and src is not $0.
  function automatic logic slot_hit(input slot_t s, input logic [REG_W-1:0] src, input logic used);
    return used && s.valid && s.regwrite && (s.dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage request and forwarding/hazard response bundle of fwd_hazard_ctrl.
// The decode stage is the master; the controller is the slave.
interface fwd_hazard_ctrl_if;
  import fwd_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] id_dst;
  logic             id_regwrite;
  logic             id_load;
  logic             ext_stall;
  logic             flush;

  logic [SEL_W-1:0] fwd_sel_rs;
  logic [SEL_W-1:0] fwd_sel_rt;
  logic             stall_id;
  logic             bubble_ex;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_dst, id_regwrite, id_load, ext_stall, flush,
    input  fwd_sel_rs, fwd_sel_rt, stall_id, bubble_ex, stall_count
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_dst, id_regwrite, id_load, ext_stall, flush,
    output fwd_sel_rs, fwd_sel_rt, stall_id, bubble_ex, stall_count
  );

endinterface

// File: rtl/fwd_src_resolve.sv
// Resolves one source operand against the EX/MEM/WB shadow slots.
// Youngest hit wins; a load hit in EX or MEM cannot be forwarded and flags load_hit instead.
module fwd_src_resolve
  import fwd_pkg::*;
(
  input  logic [REG_W-1:0] src,
  input  logic             used,
  input  slot_t            ex_slot,
  input  slot_t            mem_slot,
  input  slot_t            wb_slot,
  output logic [SEL_W-1:0] sel,
  output logic             load_hit
);

  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic unused_wb_load;

  assign ex_hit  = slot_hit(ex_slot,  src, used);
  assign mem_hit = slot_hit(mem_slot, src, used);
  assign wb_hit  = slot_hit(wb_slot,  src, used);

  // Load data is valid by WB, so the WB slot forwards regardless of its load flag.
  assign unused_wb_load = wb_slot.load;

  always_comb begin
    // NOTE: every output gets a default before the priority chain, so no path leaves it unassigned (no latch).
    sel      = FWD_RF;
    load_hit = 1'b0;
    if (ex_hit) begin
      if (ex_slot.load) load_hit = 1'b1;
      else              sel      = FWD_EX;
    end else if (mem_hit) begin
      if (mem_slot.load) load_hit = 1'b1;
      else               sel      = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding/hazard controller: shadows EX/MEM/WB destinations, drives the operand
// mux selects, raises load-use stalls, inserts EX bubbles and counts stall cycles.
module fwd_hazard_ctrl
  import fwd_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  fwd_hazard_ctrl_if.slave bus
);

  slot_t            ex_q;
  slot_t            mem_q;
  slot_t            wb_q;
  slot_t            id_slot;
  logic [CNT_W-1:0] cnt_q;

  logic [SEL_W-1:0] sel_rs;
  logic [SEL_W-1:0] sel_rt;
  logic             rs_load_hit;
  logic             rt_load_hit;
  logic             stall;
  logic             accept;

  fwd_src_resolve u_rs (
    .src      (bus.id_rs),
    .used     (bus.id_rs_used),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (sel_rs),
    .load_hit (rs_load_hit)
  );

  fwd_src_resolve u_rt (
    .src      (bus.id_rt),
    .used     (bus.id_rt_used),
    .ex_slot  (ex_q),
    .mem_slot (mem_q),
    .wb_slot  (wb_q),
    .sel      (sel_rt),
    .load_hit (rt_load_hit)
  );

  // A squashed instruction never waits on a load; flush overrides the stall.
  assign stall  = bus.id_valid && !bus.flush && (rs_load_hit || rt_load_hit);
  assign accept = bus.id_valid && !bus.flush && !stall;

  assign id_slot = accept ? '{valid: 1'b1, dst: bus.id_dst, regwrite: bus.id_regwrite, load: bus.id_load}
                          : SLOT_EMPTY;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the whole slot is cleared, not only valid, so shadow state is never X after reset.
      ex_q  <= SLOT_EMPTY;
      mem_q <= SLOT_EMPTY;
      wb_q  <= SLOT_EMPTY;
      cnt_q <= '0;
    end else if (!bus.ext_stall) begin
      // NOTE: non-blocking assignments make each stage take its neighbour's pre-edge value.
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= id_slot;
      if (stall && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.fwd_sel_rs  = sel_rs;
  assign bus.fwd_sel_rt  = sel_rt;
  assign bus.stall_id    = stall;
  assign bus.bubble_ex   = !bus.ext_stall && bus.id_valid && (stall || bus.flush);
  assign bus.stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scenario bench for fwd_hazard_ctrl: each task drives ID cycles, queues the expected outputs
// and compares them at the falling edge of the same cycle.
module tb_fwd_hazard_ctrl;
  import fwd_pkg::*;

  localparam int OBS_W = 2 * SEL_W + 2 + CNT_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fwd_hazard_ctrl_if bus ();

  fwd_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string            name;
    logic [SEL_W-1:0] rs;
    logic [SEL_W-1:0] rt;
    logic             st;
    logic             bub;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  int               total = 0;
  int               bad   = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic drive(input logic v, input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                       input logic rsu, input logic rtu, input logic [REG_W-1:0] dst,
                       input logic rw, input logic ld);
    bus.id_valid    = v;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rs_used  = rsu;
    bus.id_rt_used  = rtu;
    bus.id_dst      = dst;
    bus.id_regwrite = rw;
    bus.id_load     = ld;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Queue what this cycle must show, then advance the reference stall counter for the coming edge.
  task automatic push(input string n, input logic [SEL_W-1:0] rs, input logic [SEL_W-1:0] rt,
                      input logic st, input logic bub);
    exp_t e;
    e.name = n;
    e.rs   = rs;
    e.rt   = rt;
    e.st   = st;
    e.bub  = bub;
    e.cnt  = exp_cnt;
    sb.push_back(e);
    if (reset) exp_cnt = '0;
    else if (st && !bus.ext_stall && (exp_cnt != '1)) exp_cnt = exp_cnt + 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      idle();
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [OBS_W-1:0] observed();
    return {bus.fwd_sel_rs, bus.fwd_sel_rt, bus.stall_id, bus.bubble_ex, bus.stall_count};
  endfunction

  function automatic logic [OBS_W-1:0] wanted(input exp_t e);
    return {e.rs, e.rt, e.st, e.bub, e.cnt};
  endfunction

  function automatic string show(input logic [OBS_W-1:0] v);
    return $sformatf("rs=%0d rt=%0d stall=%b bubble=%b count=%0d",
                     v[OBS_W-1 -: SEL_W], v[OBS_W-1-SEL_W -: SEL_W], v[CNT_W+1], v[CNT_W], v[CNT_W-1:0]);
  endfunction

  task automatic test_reset();
    exp_t e;
    reset   = 1'b1;
    exp_cnt = '0;
    idle();
    @(posedge clk); #1;
    for (int s = 0; s < 2; s++) begin
      case (s)
        0: begin drive(1, 3, 4, 1, 1, 6, 1, 0); push("reset_hold", FWD_RF, FWD_RF, 0, 0); end
        default: begin reset = 1'b0; drive(1, 3, 4, 1, 1, 6, 1, 0); push("reset_release", FWD_RF, FWD_RF, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fwd_ex();
    exp_t e;
    drain();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin drive(1, 1, 2, 1, 1, 3, 1, 0); push("ex_add3",     FWD_RF,  FWD_RF,  0, 0); end
        1: begin drive(1, 3, 7, 1, 1, 8, 1, 0); push("ex_fwd_rs",   FWD_EX,  FWD_RF,  0, 0); end
        2: begin drive(1, 3, 8, 1, 1, 9, 1, 0); push("mem_ex_fwd",  FWD_MEM, FWD_EX,  0, 0); end
        default: begin drive(1, 3, 8, 1, 1, 0, 0, 0); push("wb_mem_fwd", FWD_WB, FWD_MEM, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_youngest();
    exp_t e;
    drain();
    for (int s = 0; s < 5; s++) begin
      case (s)
        0: begin drive(1, 1, 2, 1, 1, 5, 1, 0); push("yng_sub5",    FWD_RF, FWD_RF,  0, 0); end
        1: begin drive(1, 5, 5, 0, 0, 5, 1, 0); push("yng_unused",  FWD_RF, FWD_RF,  0, 0); end
        2: begin drive(1, 5, 5, 0, 1, 0, 0, 0); push("yng_ex_wins", FWD_RF, FWD_EX,  0, 0); end
        3: begin drive(1, 5, 5, 0, 1, 0, 0, 0); push("yng_mem",     FWD_RF, FWD_MEM, 0, 0); end
        default: begin drive(1, 5, 5, 0, 1, 0, 0, 0); push("yng_wb_only", FWD_RF, FWD_WB, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mem_load_shadowed();
    exp_t e;
    drain();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin drive(1, 1, 2, 1, 0, 6, 1, 1); push("shd_lw6",      FWD_RF,  FWD_RF,  0, 0); end
        1: begin drive(1, 6, 6, 0, 0, 6, 1, 0); push("shd_add6",     FWD_RF,  FWD_RF,  0, 0); end
        2: begin drive(1, 6, 6, 1, 1, 0, 0, 0); push("shd_ex_over",  FWD_EX,  FWD_EX,  0, 0); end
        default: begin drive(1, 6, 6, 1, 1, 0, 0, 0); push("shd_mem_over", FWD_MEM, FWD_MEM, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    drain();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin drive(1, 1, 2, 1, 0, 4, 1, 1); push("lu_lw4",    FWD_RF, FWD_RF, 0, 0); end
        1: begin drive(1, 4, 6, 1, 1, 10, 1, 0); push("lu_stall1", FWD_RF, FWD_RF, 1, 1); end
        2: begin drive(1, 4, 6, 1, 1, 10, 1, 0); push("lu_stall2", FWD_RF, FWD_RF, 1, 1); end
        default: begin drive(1, 4, 6, 1, 1, 10, 1, 0); push("lu_release", FWD_WB, FWD_RF, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_zero_reg();
    exp_t e;
    drain();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin drive(1, 1, 2, 1, 1, 0, 1, 0); push("z_add0",  FWD_RF, FWD_RF, 0, 0); end
        1: begin drive(1, 0, 0, 1, 1, 0, 1, 1); push("z_ex_r0", FWD_RF, FWD_RF, 0, 0); end
        default: begin drive(1, 0, 0, 1, 1, 0, 0, 0); push("z_lw0_r0", FWD_RF, FWD_RF, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    exp_t e;
    drain();
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin bus.flush = 1'b0; drive(1, 1, 2, 1, 0, 4, 1, 1); push("fl_lw4", FWD_RF, FWD_RF, 0, 0); end
        1: begin bus.flush = 1'b1; drive(1, 4, 2, 1, 1, 10, 1, 0); push("fl_wins", FWD_RF, FWD_RF, 0, 1); end
        default: begin bus.flush = 1'b0; drive(0, 4, 2, 1, 1, 10, 1, 0); push("fl_invalid_id", FWD_RF, FWD_RF, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
    bus.flush = 1'b0;
  endtask

  task automatic test_ext_stall();
    exp_t e;
    drain();
    for (int s = 0; s < 7; s++) begin
      case (s)
        0: begin drive(1, 1, 2, 1, 0, 7, 1, 1); push("es_lw7", FWD_RF, FWD_RF, 0, 0); end
        1: begin drive(1, 7, 0, 1, 1, 11, 1, 0); push("es_stall", FWD_RF, FWD_RF, 1, 1); end
        2, 3, 4: begin
          bus.ext_stall = 1'b1;
          drive(1, 7, 0, 1, 1, 11, 1, 0);
          push($sformatf("es_frozen%0d", s), FWD_RF, FWD_RF, 1, 0);
        end
        5: begin bus.ext_stall = 1'b0; drive(1, 7, 0, 1, 1, 11, 1, 0); push("es_resume", FWD_RF, FWD_RF, 1, 1); end
        default: begin drive(1, 7, 0, 1, 1, 11, 1, 0); push("es_release", FWD_WB, FWD_RF, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
    bus.ext_stall = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    exp_t e;
    drain();
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin drive(1, 1, 2, 1, 0, 7, 1, 1); push("rm_lw7", FWD_RF, FWD_RF, 0, 0); end
        1: begin drive(1, 3, 7, 0, 1, 12, 1, 0); push("rm_stall", FWD_RF, FWD_RF, 1, 1); end
        2: begin reset = 1'b1; drive(1, 3, 7, 0, 1, 12, 1, 0); push("rm_reset_cycle", FWD_RF, FWD_RF, 1, 1); end
        default: begin reset = 1'b0; drive(1, 3, 7, 0, 1, 12, 1, 0); push("rm_cleared", FWD_RF, FWD_RF, 0, 0); end
      endcase
      @(negedge clk);
      e = sb.pop_front();
      total++;
      if (observed() !== wanted(e)) begin
        bad++;
        $display("FAIL %s: got %s, need %s", e.name, show(observed()), show(wanted(e)));
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.ext_stall = 1'b0;
    exp_cnt       = '0;
    idle();
    test_reset();
    test_fwd_ex();
    test_youngest();
    test_mem_load_shadowed();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_ext_stall();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
